// File: rtl/sram_1rw1r_ctrl.sv
// Client write/read channels onto a 1rw1r SRAM macro, with a credit-checked read response FIFO.
// Define SRAM_CLEAR_ON_RESET_EN to zero the whole array through port 0 after every reset.
module sram_1rw1r_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_WMASKS-1:0] wr_mask,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1) + 1;

    logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_d [RSP_DEPTH];
    logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  inflight_q, inflight_d;
    logic                  run, sweeping;
    logic [ADDR_WIDTH-1:0] sweep_addr;

`ifdef SRAM_CLEAR_ON_RESET_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == ST_INIT) begin
            clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
            if (clr_addr_q == '1) state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign run        = (state_q == ST_RUN);
    assign sweeping   = (state_q == ST_INIT) && !rst;
    assign sweep_addr = clr_addr_q;
`else
    logic run_q, run_d;

    assign run_d = 1'b1;
    always_ff @(posedge clk) begin
        if (rst) run_q <= 1'b0;
        else     run_q <= run_d;
    end

    assign run        = run_q;
    assign sweeping   = 1'b0;
    assign sweep_addr = '0;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic          active, hazard, wr_fire, rd_fire, pop, push;
    logic [CW-1:0] used;

    always_comb begin
        active = run && !rst;
        hazard = wr_valid && rd_valid && (wr_addr == rd_addr) && (wr_mask != '0);
        pop    = (cnt_q != '0) && rsp_ready;
        push   = inflight_q;
        // Credits count the read already at the macro, so a push can never overflow.
        used     = cnt_q + CW'(inflight_q) - CW'(pop);
        wr_ready = active;
        rd_ready = active && !hazard && (used < CW'(RSP_DEPTH));
        wr_fire  = wr_valid && wr_ready;
        rd_fire  = rd_valid && rd_ready;

        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        if (sweeping) begin
            sram_csb0   = 1'b0;
            sram_web0   = 1'b0;
            sram_wmask0 = '1;
            sram_addr0  = sweep_addr;
        end else if (wr_fire && (wr_mask != '0)) begin
            sram_csb0   = 1'b0;
            sram_web0   = 1'b0;
            sram_wmask0 = wr_mask;
            sram_addr0  = wr_addr;
            sram_din0   = wr_data;
        end

        sram_csb1  = !rd_fire;
        sram_addr1 = rd_fire ? rd_addr : '0;

        fifo_d     = fifo_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q + CW'(push) - CW'(pop);
        inflight_d = rd_fire;
        if (push) begin
            fifo_d[wptr_q] = sram_dout1;
            wptr_d         = ptr_inc(wptr_q);
        end
        if (pop) rptr_d = ptr_inc(rptr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            fifo_q     <= fifo_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
        end
    end

    assign rsp_valid = (cnt_q != '0);
    assign rsp_data  = fifo_q[rptr_q];
    assign init_done = run;
endmodule

// File: tb/tb_sram_1rw1r_ctrl.sv
// Bench for sram_1rw1r_ctrl: macro model, transaction-level reference model, directed and random traffic.
module tb_sram_1rw1r_ctrl;
    localparam int AW = 8, DW = 32, NM = 4, RD = 2;
`ifdef SRAM_CLEAR_ON_RESET_EN
    localparam int SWEEP = 1 << AW;
`else
    localparam int SWEEP = 1;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic wr_valid = 0, wr_ready, rd_valid = 0, rd_ready, rsp_valid, rsp_ready = 0, init_done;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0, sram_addr0, sram_addr1;
    logic [DW-1:0] wr_data = '0, rsp_data, sram_din0, sram_dout1 = '0;
    logic [NM-1:0] wr_mask = '0, sram_wmask0;
    logic sram_csb0, sram_web0, sram_csb1;

    always #5 clk = ~clk;

    sram_1rw1r_ctrl dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .init_done(init_done),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
    );

    // Macro model: both ports sample at the posedge, read data appears the following cycle.
    logic [DW-1:0] mac_mem [1 << AW];
    logic [DW-1:0] ref_mem [1 << AW];
    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mac_mem[i] = 32'hDEAD_0000 | i;
            ref_mem[i] = 32'hDEAD_0000 | i;
        end
    end
    always @(posedge clk) begin
        if (!sram_csb0 && !sram_web0)
            for (int b = 0; b < NM; b++)
                if (sram_wmask0[b]) mac_mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
        if (!sram_csb1) sram_dout1 <= mac_mem[sram_addr1];
    end

    int vectors = 0, miscompares = 0;
    int unsigned cyc = 0, run_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: outstanding reads as a queue of {data, accept cycle}.
    typedef struct packed { logic [DW-1:0] data; int unsigned t; } rsp_t;
    rsp_t q[$];

    always @(negedge clk) begin
        logic run_e, act_e, hz, ev, pop, rdy_e, rf, wf, init_e;
        logic c0, w0;
        logic [NM-1:0] m0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        run_e  = (run_cnt >= SWEEP);
        act_e  = run_e && !rst;
        init_e = (SWEEP > 1) && !run_e && !rst;
        hz     = wr_valid && rd_valid && (wr_addr == rd_addr) && (wr_mask != 0);
        ev     = (q.size() > 0) && (cyc - q[0].t >= 2);
        pop    = ev && rsp_ready;
        rdy_e  = act_e && !hz && ((int'(q.size()) - int'(pop)) < RD);
        rf     = rd_valid && rdy_e;
        wf     = wr_valid && act_e;
        {c0, w0, m0, a0, d0} = {1'b1, 1'b1, 4'h0, 8'h00, 32'h0};
        if (init_e) {c0, w0, m0, a0, d0} = {1'b0, 1'b0, 4'hF, run_cnt[AW-1:0], 32'h0};
        else if (wf && wr_mask != 0) {c0, w0, m0, a0, d0} = {1'b0, 1'b0, wr_mask, wr_addr, wr_data};

        check("init_done", init_done, run_e);
        check("wr_ready", wr_ready, act_e);
        check("rd_ready", rd_ready, rdy_e);
        check("rsp_valid", rsp_valid, ev);
        if (ev) check("rsp_data", rsp_data, q[0].data);
        check("sram_csb0", sram_csb0, c0);
        check("sram_web0", sram_web0, w0);
        check("sram_wmask0", sram_wmask0, m0);
        check("sram_addr0", sram_addr0, a0);
        check("sram_din0", sram_din0, d0);
        check("sram_csb1", sram_csb1, !rf);
        check("sram_addr1", sram_addr1, rf ? rd_addr : 8'h00);

        if (rst) begin
            q.delete();
            run_cnt = 0;
`ifdef SRAM_CLEAR_ON_RESET_EN
            for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
`endif
        end else begin
            if (pop) void'(q.pop_front());
            if (rf) q.push_back('{data: ref_mem[rd_addr], t: cyc});
            if (wf && wr_mask != 0)
                for (int b = 0; b < NM; b++)
                    if (wr_mask[b]) ref_mem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
            if (run_cnt < 100000) run_cnt++;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init();
        int n = 0, wcnt = 0;
        @(negedge clk);
        while (!init_done && n < 400) begin
            if (!sram_csb0 && !sram_web0 && sram_din0 == 0 && sram_wmask0 == 4'hF && sram_addr0 == n[AW-1:0]) wcnt++;
            n++;
            @(negedge clk);
        end
        check("init_cycles", n, SWEEP);
`ifdef SRAM_CLEAR_ON_RESET_EN
        check("sweep_writes", wcnt, 256);
`endif
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NM-1:0] m);
        int n = 0;
        tick();
        wr_valid = 1; wr_addr = a; wr_data = d; wr_mask = m;
        @(negedge clk);
        while (!wr_ready && n < 50) begin @(negedge clk); n++; end
        if (!wr_ready) check("wr_accept_timeout", 0, 1);
        tick();
        wr_valid = 0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
        int n = 0;
        tick();
        rd_valid = 1; rd_addr = a; rsp_ready = 1;
        @(negedge clk);
        while (!rd_ready && n < 50) begin @(negedge clk); n++; end
        if (!rd_ready) check("rd_accept_timeout", 0, 1);
        tick();
        rd_valid = 0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin lat++; @(negedge clk); end
        d = rsp_data;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        int lat, acc;
        repeat (3) tick();
        @(negedge clk);
        check("rst_init_done", init_done, 0);
        check("rst_csb0", sram_csb0, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rd_ready", rd_ready, 0);
        tick();
        rst = 0;
        wait_init();

`ifdef SRAM_CLEAR_ON_RESET_EN
        do_read(8'h7F, d, lat);
        check("clear_read_7f", d, 32'h0000_0000);
`endif

        do_write(8'h10, 32'hAABBCCDD, 4'b1111);
        do_write(8'h10, 32'h11223344, 4'b0101);
        do_read(8'h10, d, lat);
        check("masked_data", d, 32'hAA22CC44);
        check("masked_latency", lat, 2);

        for (int i = 0; i < 8; i++) do_write(8'(i), 32'h100 + i, 4'hF);
        tick();
        rsp_ready = 1;
        for (int c = 0; c < 12; c++) begin
            rd_valid = (c < 8);
            rd_addr  = c[AW-1:0];
            @(negedge clk);
            if (c < 8) check("stream_rd_ready", rd_ready, 1);
            if (c >= 2 && c < 10) begin
                check("stream_rsp_valid", rsp_valid, 1);
                check("stream_data", rsp_data, 32'h100 + c - 2);
            end
            tick();
        end
        rd_valid = 0;

        rsp_ready = 0; rd_valid = 1; rd_addr = 0; acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rd_ready) acc++;
            if (c >= 2) begin
                check("bp_rsp_valid", rsp_valid, 1);
                check("bp_hold_data", rsp_data, 32'h100);
            end
            tick();
            rd_addr = acc[AW-1:0];
        end
        check("bp_accepts", acc, 2);
        rd_valid = 0; rsp_ready = 1;
        @(negedge clk);
        check("bp_drain0", rsp_data, 32'h100);
        tick();
        @(negedge clk);
        check("bp_drain1", rsp_data, 32'h101);
        tick();
        rd_valid = 1; rd_addr = 8'h10;
        @(negedge clk);
        check("bp_empty", rsp_valid, 0);
        check("bp_resume", rd_ready, 1);
        tick();
        rd_valid = 0;
        repeat (3) tick();

        wr_valid = 1; wr_addr = 8'h20; wr_data = 32'h5; wr_mask = 4'hF;
        rd_valid = 1; rd_addr = 8'h20;
        @(negedge clk);
        check("hz_wr_ready", wr_ready, 1);
        check("hz_rd_stall", rd_ready, 0);
        tick();
        wr_valid = 0;
        @(negedge clk);
        check("hz_rd_retry", rd_ready, 1);
        tick();
        rd_valid = 0;
        @(negedge clk);
        @(negedge clk);
        check("hz_rsp_valid", rsp_valid, 1);
        check("hz_data", rsp_data, 32'h0000_0005);
        tick();
        wr_valid = 1; wr_addr = 8'h20; wr_data = 32'h6; wr_mask = 4'hF;
        rd_valid = 1; rd_addr = 8'h21;
        @(negedge clk);
        check("nohz_wr_ready", wr_ready, 1);
        check("nohz_rd_ready", rd_ready, 1);
        tick();
        wr_valid = 0; rd_valid = 0;
        repeat (3) tick();

        rsp_ready = 0; rd_valid = 1; rd_addr = 8'h02;
        tick();
        rd_addr = 8'h03;
        tick();
        rd_valid = 0; rst = 1;
        tick();
        @(negedge clk);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        tick();
        rst = 0;
        wait_init();
        rsp_ready = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rst_no_stale", rsp_valid, 0);
            tick();
        end

        for (int i = 0; i < 3000; i++) begin
            tick();
            wr_valid  = 1'($urandom_range(0, 1));
            wr_addr   = 8'($urandom_range(0, 7));
            wr_data   = $urandom;
            wr_mask   = 4'($urandom_range(0, 15));
            rd_valid  = 1'($urandom_range(0, 1));
            rd_addr   = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) rd_addr = wr_addr;
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        wr_valid = 0; rd_valid = 0; rsp_ready = 1;
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sram_1rw1r_ctrl.md
Name: sram_1rw1r_ctrl

Overview:
Initiator-side controller for the 1rw1r 32x256 byte-masked SRAM macro. Accepts client write requests on a valid/ready channel and drives them onto macro port 0 (RW, used write-only). Accepts client read requests on a second valid/ready channel, issues them on macro port 1 (R), and returns read data through a credit-checked response buffer. Sits between enclave datapath clients and each SRAM instance.

Parameters:
ADDR_WIDTH, 8, word address width; depth = 1<<ADDR_WIDTH
DATA_WIDTH, 32, word width
NUM_WMASKS, 4, byte-lane write mask width (DATA_WIDTH/8)
RSP_DEPTH, 2, read response FIFO entries (>=2)

Ports:
clk  in  1  single clock; the macro's clk0 and clk1 are both tied to this clock
rst  in  1  synchronous, active-high reset
wr_valid  in  1  write request valid
wr_ready  out  1  write request accepted when wr_valid&wr_ready
wr_addr  in  ADDR_WIDTH  write word address
wr_data  in  DATA_WIDTH  write data
wr_mask  in  NUM_WMASKS  byte enables
rd_valid  in  1  read request valid
rd_ready  out  1  read request accepted when rd_valid&rd_ready
rd_addr  in  ADDR_WIDTH  read word address
rsp_valid  out  1  read data valid
rsp_ready  in  1  consumer ready
rsp_data  out  DATA_WIDTH  read data, in request order
init_done  out  1  high once the controller is in RUN
sram_csb0  out  1  macro port0 chip select, active low
sram_web0  out  1  macro port0 write enable, active low
sram_wmask0  out  NUM_WMASKS  macro port0 mask
sram_addr0  out  ADDR_WIDTH  macro port0 address
sram_din0  out  DATA_WIDTH  macro port0 data
sram_csb1  out  1  macro port1 chip select, active low
sram_addr1  out  ADDR_WIDTH  macro port1 address
sram_dout1  in  DATA_WIDTH  macro port1 read data

Behaviour:
- Reset, sampled at the clk posedge: state=INIT (or RUN, see the optional feature); FIFO empty; in-flight flag=0. Outputs during and after reset: rsp_valid=0, init_done=0, wr_ready=0, rd_ready=0, sram_csb0=1, sram_csb1=1, sram_web0=1, other sram_* = 0.
- Macro outputs are combinational from the accepted handshake in the same cycle. The macro samples them at the next posedge.
- Writes:
  - wr_ready=1 in RUN.
  - On accept: sram_csb0=0, sram_web0=0; addr, data and mask are passed through.
  - wr_mask==0 is accepted as a no-op with sram_csb0 held at 1.
  - sram_web0 is never driven 0 with sram_csb0=1.
- Reads:
  - rd_ready = RUN && !hazard && (fifo_count + inflight - pop) < RSP_DEPTH, where pop = rsp_valid&rsp_ready. The combinational rsp_ready->rd_ready path is intentional.
  - Read accepted in cycle N: sram_csb1=0, sram_addr1=rd_addr; inflight=1 for cycle N+1.
  - At the end of cycle N+1, sram_dout1 is pushed into the FIFO.
  - rsp_valid is high from cycle N+2, giving a fixed 2-cycle accept-to-response latency.
  - One read per cycle is sustained when rsp_ready is held high.
- Hazard:
  - Condition: wr_valid && rd_valid && wr_addr==rd_addr && wr_mask!=0 in the same cycle.
  - Write wins; rd_ready=0 that cycle.
  - A read in the cycle after a same-address write returns the new data.
- FIFO:
  - rsp_data is the FIFO head and stays stable while rsp_valid && !rsp_ready.
  - Push and pop in the same cycle keep the count unchanged.
  - FIFO overflow is impossible by the credit rule.
- FSM:
  - INIT: a counter sweeps addr 0..depth-1, writing 0 with full mask via port 0 (sram_csb0=0, sram_web0=0). Client ready signals are 0.
  - After the last address is written: go to RUN and set init_done=1.
  - RUN: normal operation; no exit except rst.
- rst asserted mid-INIT restarts the sweep at addr 0. rst asserted mid-read drops the in-flight and buffered data.

Optional Feature:
SRAM_CLEAR_ON_RESET_EN:
- Defined: reset enters INIT, and the zeroing sweep takes 1<<ADDR_WIDTH cycles (256 by default) before init_done=1.
- Undefined: reset enters RUN directly. init_done=1 the first cycle after reset deasserts, and no INIT logic or counter is built. Memory contents are undefined until written.

Test Plan:
- Clear sweep (feature on): reset, then count cycles until init_done -> exactly 256 port0 writes of 0 to addr 0..255; a subsequent read of addr 0x7F returns 0x00000000.
- Masked write: write addr 0x10 data 0xAABBCCDD mask 4'b1111, then addr 0x10 data 0x11223344 mask 4'b0101, then read -> rsp_data=0xAA22CC44, rsp_valid exactly 2 cycles after the read accept.
- Streaming reads: 8 back-to-back reads of addr 0..7 with rsp_ready=1 -> rd_ready stays 1, eight responses in order on 8 consecutive cycles.
- Backpressure: rsp_ready=0 while issuing reads -> rd_ready drops after 2 accepts; rsp_data is held stable; raising rsp_ready drains both entries, then accepts resume.
- Hazard: same-cycle write addr 0x20 data 0x5 and read addr 0x20 -> write accepted, read stalled one cycle, and the read returns 0x00000005; with rd_addr 0x21 both are accepted in the same cycle.
- Reset mid-stream: assert rst with 2 reads in flight or buffered -> rsp_valid=0 the next cycle, and no stale response appears after the restart.
